regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised MIPS register file with an integrated hazard scoreboard for the pipelined core. It has two combinational read ports and one synchronous writeback port. Each register has a pending-write counter rather than a single flag, so several in-flight writes to the same register are tracked correctly. Decode uses the ready outputs to stall; writeback retires pending writes.

Parameters:
NUM_REGS, 32, number of architectural registers; power of two, minimum 2
DATA_W, 32, register width in bits
ADDR_W, $clog2(NUM_REGS), register index width
PEND_W, 2, pending-counter width per register; maximum in-flight writes per register is 2^PEND_W-1

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
rd_addr1  input  ADDR_W  read port 1 index (Rs)
rd_addr2  input  ADDR_W  read port 2 index (Rt)
rd_data1  output  DATA_W  read port 1 data, combinational
rd_data2  output  DATA_W  read port 2 data, combinational
rd_ready1  output  1  1 = no pending write on rd_addr1
rd_ready2  output  1  1 = no pending write on rd_addr2
issue_en  input  1  decode issues an instruction that writes a register (regWriteD)
issue_dst_sel  input  1  0 = destination is issue_rt, 1 = destination is issue_rd (regDstD)
issue_rt  input  ADDR_W  Rt field at decode
issue_rd  input  ADDR_W  Rd field at decode
issue_full  output  1  1 = the selected destination's counter is saturated; decode must stall
wb_en  input  1  writeback valid (regWriteW)
wb_addr  input  ADDR_W  writeback destination
wb_data  input  DATA_W  writeback value
err_underflow  output  1  sticky: a writeback arrived for a register whose counter was 0

Behaviour:
- Reset:
  - All registers clear to 0.
  - All counters clear to 0.
  - err_underflow clears to 0.
  - Consequences: rd_ready1/2 = 1, issue_full = 0, rd_data = 0.
  - Reset overrides issue_en and wb_en in the same cycle.
- Register 0:
  - Always reads 0 and is always ready.
  - Writes to it are ignored.
  - Issues to it are ignored and issue_full is 0.
  - Writebacks to it never set err_underflow.
- Read:
  - rd_dataN = regs[rd_addrN], combinational.
  - rd_readyN = (pend[rd_addrN] == 0).
- Write:
  - If wb_en and wb_addr != 0, regs[wb_addr] <= wb_data at the clock edge.
  - Without bypass, the new value is visible on reads the cycle after the edge.
- Destination select: dst = issue_dst_sel ? issue_rd : issue_rt.
- issue_full:
  - issue_full = issue_en && dst != 0 && pend[dst] == max && !(wb_en && wb_addr == dst).
  - When issue_full = 1, the issue is not accepted and the counter does not increment; decode retries.
- Counter update per register r, on each edge:
  - Accepted issue to r and no wb to r: pend[r] + 1.
  - wb to r and no accepted issue to r: pend[r] - 1, if pend[r] > 0.
  - Accepted issue and wb to r in the same cycle: unchanged (net zero; legal even when saturated).
  - wb to r with pend[r] == 0 and no issue to r: counter stays 0, data is still written, err_underflow <= 1.
  - Counters never wrap.
- err_underflow: cleared only by reset.
- Reset mid-operation: all pending state is discarded and there is no replay.
- Only one issue and one writeback per cycle; the counters are the only state besides the register array.

Optional Feature:
Macro REGFILE_WB_BYPASS_EN.
- Defined (read port N, same cycle):
  - If wb_en, wb_addr != 0 and wb_addr == rd_addrN, then rd_dataN = wb_data.
  - rd_readyN = 1 if pend[rd_addrN] <= 1 in that case. The writeback retires the last pending write, so decode sees the value and need not stall.
- Undefined:
  - No forwarding; rd_data shows the array contents only.
  - rd_ready reflects the registered counters only, so a stall lasts one cycle longer after writeback.

Test Plan:
- Reset then read r0..r31 -> all data 0, ready 1; write 0xDEADBEEF to r0 -> r0 still reads 0 and ready is 1.
- Issue dst_sel=1 rd=5 -> next cycle rd_ready for r5 = 0; wb r5=0x1234 -> following cycle r5 reads 0x1234, ready 1. With bypass, data and ready=1 appear in the wb cycle itself.
- Issue r7 three times (PEND_W=2) -> fourth issue shows issue_full=1 and counter stays 3; fourth issue coinciding with wb r7 -> accepted, counter stays 3; three more wbs -> ready 1.
- wb r9=0x55 with no prior issue -> r9 = 0x55, err_underflow = 1 and stays 1 until reset.
- Issue r3 and wb r3 in the same cycle with pend[3]=1 -> counter stays 1 and r3 stays not ready; next wb -> ready.
- Assert reset with r4 pending and data written -> next cycle r4 = 0, ready 1, err_underflow 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// MIPS register file with a per-register pending-write counter scoreboard.
// Optional same-cycle writeback-to-read forwarding is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int PEND_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_ready1,
    output logic              rd_ready2,
    input  logic              issue_en,
    input  logic              issue_dst_sel,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_full,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              err_underflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];
    logic              err_q;
    logic              err_d;

    logic [ADDR_W-1:0]   dst;
    logic                dst_nz;
    logic                wb_valid;
    logic                wb_hits_dst;
    logic                issue_acc;
    logic [NUM_REGS-1:0] inc_v;
    logic [NUM_REGS-1:0] dec_v;

    // A writeback to the saturated destination frees a slot in the same cycle.
    always_comb begin
        dst         = issue_dst_sel ? issue_rd : issue_rt;
        dst_nz      = (dst != '0);
        wb_valid    = wb_en && (wb_addr != '0);
        wb_hits_dst = wb_valid && (wb_addr == dst);
        issue_full  = issue_en && dst_nz && (pend_q[dst] == PEND_MAX) && !wb_hits_dst;
        issue_acc   = issue_en && dst_nz && !issue_full;
    end

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_v[r]  = issue_acc && (dst == ADDR_W'(r));
            dec_v[r]  = wb_valid && (wb_addr == ADDR_W'(r));
            pend_d[r] = pend_q[r];
            regs_d[r] = regs_q[r];
            if (inc_v[r] && !dec_v[r]) begin
                pend_d[r] = pend_q[r] + PEND_W'(1);
            end else if (dec_v[r] && !inc_v[r] && (pend_q[r] != '0)) begin
                pend_d[r] = pend_q[r] - PEND_W'(1);
            end
            if (dec_v[r]) begin
                regs_d[r] = wb_data;
            end
        end
    end

    // Underflow only when nothing was outstanding and no issue lands on the same register.
    always_comb begin
        err_d = err_q;
        if (wb_valid && (pend_q[wb_addr] == '0) && !(issue_acc && (dst == wb_addr))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
                pend_q[r] <= pend_d[r];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        rd_data1  = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
        rd_data2  = (rd_addr2 == '0) ? '0 : regs_q[rd_addr2];
        rd_ready1 = (rd_addr1 == '0) || (pend_q[rd_addr1] == '0);
        rd_ready2 = (rd_addr2 == '0) || (pend_q[rd_addr2] == '0);
`ifdef REGFILE_WB_BYPASS_EN
        // The retiring writeback completes the last outstanding write when pend <= 1.
        if (wb_valid && (wb_addr == rd_addr1)) begin
            rd_data1  = wb_data;
            rd_ready1 = (pend_q[rd_addr1] <= PEND_W'(1));
        end
        if (wb_valid && (wb_addr == rd_addr2)) begin
            rd_data2  = wb_data;
            rd_ready2 = (pend_q[rd_addr2] <= PEND_W'(1));
        end
`endif
    end

    assign err_underflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_scoreboard;
    localparam int NR   = 32;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int PW   = 2;
    localparam int PMAX = 3;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_ready1, rd_ready2;
    logic          issue_en, issue_dst_sel;
    logic [AW-1:0] issue_rt, issue_rd;
    logic          issue_full;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          err_underflow;

    regfile_scoreboard #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .PEND_W(PW)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_ready1(rd_ready1), .rd_ready2(rd_ready2),
        .issue_en(issue_en), .issue_dst_sel(issue_dst_sel),
        .issue_rt(issue_rt), .issue_rd(issue_rd), .issue_full(issue_full),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] regs_m [NR];
    int            pend_m [NR];
    bit            err_m;

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    function automatic bit byp_hit(input logic [AW-1:0] a);
        return BYP && wb_en && (wb_addr != 0) && (wb_addr == a);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (byp_hit(a)) return wb_data;
        return regs_m[a];
    endfunction

    function automatic logic exp_ready(input logic [AW-1:0] a);
        return (a == 0) || (pend_m[a] == 0) || (byp_hit(a) && pend_m[a] <= 1);
    endfunction

    function automatic logic exp_full();
        logic [AW-1:0] d;
        d = issue_dst_sel ? issue_rd : issue_rt;
        return issue_en && (d != 0) && (pend_m[d] >= PMAX) && !(wb_en && wb_addr == d);
    endfunction

    // Reference state: plain integers per register, updated at each rising edge.
    always @(posedge clk) begin : model
        int  d;
        bit  acc, wbv;
        if (reset) begin
            for (int r = 0; r < NR; r++) begin
                regs_m[r] = '0;
                pend_m[r] = 0;
            end
            err_m = 1'b0;
        end else begin
            d   = int'(issue_dst_sel ? issue_rd : issue_rt);
            acc = issue_en && (d != 0) && !(pend_m[d] >= PMAX && !(wb_en && int'(wb_addr) == d));
            wbv = wb_en && (wb_addr != 0);
            if (wbv && pend_m[wb_addr] == 0 && !(acc && d == int'(wb_addr))) err_m = 1'b1;
            if (wbv) regs_m[wb_addr] = wb_data;
            if (acc) pend_m[d] = pend_m[d] + 1;
            if (wbv && pend_m[wb_addr] > 0) pend_m[wb_addr] = pend_m[wb_addr] - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chkw("rd_data1", rd_data1, exp_data(rd_addr1));
            chkw("rd_data2", rd_data2, exp_data(rd_addr2));
            chkb("rd_ready1", rd_ready1, exp_ready(rd_addr1));
            chkb("rd_ready2", rd_ready2, exp_ready(rd_addr2));
            chkb("issue_full", issue_full, exp_full());
            chkb("err_underflow", err_underflow, err_m);
        end
    end

    task automatic idle();
        issue_en = 1'b0; issue_dst_sel = 1'b0; issue_rt = '0; issue_rd = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1; rd_addr1 = '0; rd_addr2 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Reset contents and register 0
        for (int r = 0; r < NR; r++) begin
            step(); rd_addr1 = AW'(r); rd_addr2 = AW'(NR - 1 - r);
            @(negedge clk);
            chkw("t1_data1", rd_data1, 32'h0); chkb("t1_ready1", rd_ready1, 1'b1);
            chkw("t1_data2", rd_data2, 32'h0); chkb("t1_ready2", rd_ready2, 1'b1);
        end
        step(); wb_en = 1'b1; wb_addr = '0; wb_data = 32'hDEADBEEF; rd_addr1 = '0;
        @(negedge clk); chkw("r0_wbcyc_data", rd_data1, 32'h0);
        step(); idle();
        @(negedge clk);
        chkw("r0_data", rd_data1, 32'h0); chkb("r0_ready", rd_ready1, 1'b1);
        chkb("r0_err", err_underflow, 1'b0);

        // Issue via rd field, then writeback
        step(); idle(); issue_en = 1'b1; issue_dst_sel = 1'b1; issue_rd = 5'd5; issue_rt = 5'd9;
        rd_addr1 = 5'd5; rd_addr2 = 5'd9;
        @(negedge clk); chkb("t2_full", issue_full, 1'b0);
        step(); idle();
        @(negedge clk); chkb("t2_r5_busy", rd_ready1, 1'b0); chkb("t2_r9_free", rd_ready2, 1'b1);
        step(); wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        @(negedge clk);
        chkw("t2_wbcyc_data", rd_data1, BYP ? 32'h1234 : 32'h0);
        chkb("t2_wbcyc_ready", rd_ready1, BYP ? 1'b1 : 1'b0);
        step(); idle();
        @(negedge clk); chkw("t2_data", rd_data1, 32'h1234); chkb("t2_ready", rd_ready1, 1'b1);

        // Saturation of r7
        rd_addr1 = 5'd7;
        for (int i = 0; i < 3; i++) begin
            step(); idle(); issue_en = 1'b1; issue_rt = 5'd7;
            @(negedge clk); chkb("t3_fill_full", issue_full, 1'b0);
        end
        step(); idle(); issue_en = 1'b1; issue_rt = 5'd7;
        @(negedge clk); chkb("t3_full", issue_full, 1'b1); chkw("t3_model_pend7", pend_m[7], 32'd3);
        step(); idle(); issue_en = 1'b1; issue_rt = 5'd7; wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h70;
        @(negedge clk); chkb("t3_full_with_wb", issue_full, 1'b0);
        step(); idle();
        @(negedge clk); chkw("t3_model_pend7_net", pend_m[7], 32'd3); chkb("t3_busy", rd_ready1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(); idle(); wb_en = 1'b1; wb_addr = 5'd7; wb_data = DW'(i);
        end
        step(); idle(); wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2;
        @(negedge clk); chkb("t3_last_wb_ready", rd_ready1, BYP ? 1'b1 : 1'b0);
        step(); idle();
        @(negedge clk); chkb("t3_ready", rd_ready1, 1'b1); chkw("t3_data", rd_data1, 32'h2);

        // Underflow is sticky
        step(); idle(); wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55; rd_addr2 = 5'd9;
        @(negedge clk); chkb("t4_err_before", err_underflow, 1'b0);
        step(); idle();
        @(negedge clk); chkw("t4_data", rd_data2, 32'h55); chkb("t4_err", err_underflow, 1'b1);
        repeat (3) step();
        @(negedge clk); chkb("t4_err_sticky", err_underflow, 1'b1);

        // Same-cycle issue and writeback on r3
        step(); idle(); issue_en = 1'b1; issue_rt = 5'd3; rd_addr2 = 5'd3;
        step(); idle(); issue_en = 1'b1; issue_rt = 5'd3; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        @(negedge clk); chkb("t5_full", issue_full, 1'b0);
        step(); idle();
        @(negedge clk);
        chkb("t5_busy", rd_ready2, 1'b0); chkw("t5_data", rd_data2, 32'h33);
        chkw("t5_model_pend3", pend_m[3], 32'd1);
        step(); wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h34;
        step(); idle();
        @(negedge clk); chkb("t5_ready", rd_ready2, 1'b1); chkw("t5_data2", rd_data2, 32'h34);

        // Reset with r4 pending and written; reset overrides issue and writeback
        step(); idle(); issue_en = 1'b1; issue_rt = 5'd4; rd_addr1 = 5'd4;
        step();
        step(); idle(); wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hABCD;
        step(); idle();
        @(negedge clk); chkw("t6_pre_data", rd_data1, 32'hABCD); chkb("t6_pre_busy", rd_ready1, 1'b0);
        step(); reset = 1'b1; issue_en = 1'b1; issue_rt = 5'd4; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hFFFF;
        step(); reset = 1'b0; idle();
        @(negedge clk);
        chkw("t6_data", rd_data1, 32'h0); chkb("t6_ready", rd_ready1, 1'b1);
        chkb("t6_err", err_underflow, 1'b0);

        // Randomized traffic concentrated on a few registers so counters collide and saturate
        for (int c = 0; c < 3000; c++) begin
            step();
            reset         = ($urandom_range(0, 199) == 0);
            issue_en      = ($urandom_range(0, 99) < 60);
            issue_dst_sel = 1'($urandom_range(0, 1));
            issue_rt      = AW'($urandom_range(0, 7));
            issue_rd      = AW'($urandom_range(0, 7));
            wb_en         = ($urandom_range(0, 99) < 45);
            wb_addr       = AW'($urandom_range(0, 7));
            wb_data       = $urandom;
            rd_addr1      = AW'($urandom_range(0, 7));
            rd_addr2      = AW'($urandom_range(0, NR - 1));
        end
        step(); reset = 1'b0; idle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
